// File: rtl/cic_row_readout_if.sv
// Parallel-in / serial-out bundle between the CIC filter row and the readout serializer.
interface cic_row_readout_if #(
    parameter int unsigned NUM_CHANNELS = 24,
    parameter int unsigned WORD_WIDTH   = 25
);
    logic [NUM_CHANNELS*WORD_WIDTH-1:0] data_in;
    logic                               data_valid;
    logic                               overrun_clr;
    logic                               busy;
    logic                               tx_data;
    logic                               tx_frame;
    logic                               tx_bit_start;
    logic [7:0]                         frame_count;
    logic                               overrun;

    modport master (
        output data_in, data_valid, overrun_clr,
        input  busy, tx_data, tx_frame, tx_bit_start, frame_count, overrun
    );

    modport slave (
        input  data_in, data_valid, overrun_clr,
        output busy, tx_data, tx_frame, tx_bit_start, frame_count, overrun
    );
endinterface

// File: rtl/cic_row_readout.sv
// Snapshots a CIC filter row on data_valid and ships it as one framed MSB-first serial stream.
// Define CIC_READOUT_PARITY_EN to append an even-parity bit after every channel word.
module cic_row_readout #(
    parameter int unsigned NUM_CHANNELS = 24,
    parameter int unsigned WORD_WIDTH   = 25,
    parameter int unsigned CLK_DIV      = 4,
    parameter logic [7:0]  SYNC_WORD    = 8'hA5
) (
    input logic              clk,
    input logic              reset,
    cic_row_readout_if.slave bus
);
    localparam int unsigned DataBits = NUM_CHANNELS * WORD_WIDTH;
    localparam int unsigned SrBits   = 16 + DataBits;
    localparam int unsigned DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned ChW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned BitW     = (WORD_WIDTH > 8) ? $clog2(WORD_WIDTH) : 3;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StCount,
`ifdef CIC_READOUT_PARITY_EN
        StParity,
`endif
        StData
    } state_e;

    state_e            state_q;
    logic [SrBits-1:0] sr_q;
    logic [DivW-1:0]   div_q;
    logic [BitW-1:0]   bit_q;
    logic [ChW-1:0]    chan_q;
    logic              busy_q;
    logic              tx_data_q;
    logic              tx_frame_q;
    logic              tx_bit_start_q;
    logic [7:0]        count_q;
    logic              overrun_q;
`ifdef CIC_READOUT_PARITY_EN
    logic              par_q;
`endif

    // Channel 0 goes to the top so the whole frame leaves the shift register MSB first.
    logic [DataBits-1:0] snap;
    always_comb begin
        snap = '0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            snap[(NUM_CHANNELS-1-j)*WORD_WIDTH +: WORD_WIDTH] =
                bus.data_in[j*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    logic div_end, last_bit, last_chan, next_bit;
    assign div_end   = (div_q == DivW'(CLK_DIV - 1));
    assign last_bit  = (bit_q == '0);
    assign last_chan = (chan_q == ChW'(NUM_CHANNELS - 1));
    assign next_bit  = sr_q[SrBits-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            sr_q           <= '0;
            div_q          <= '0;
            bit_q          <= '0;
            chan_q         <= '0;
            busy_q         <= 1'b0;
            tx_data_q      <= 1'b0;
            tx_frame_q     <= 1'b0;
            tx_bit_start_q <= 1'b0;
            count_q        <= '0;
            overrun_q      <= 1'b0;
`ifdef CIC_READOUT_PARITY_EN
            par_q          <= 1'b0;
`endif
        end else begin
            // A drop in the same cycle as a clear leaves the flag set.
            if (bus.data_valid && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end

            if (state_q == StIdle) begin
                if (bus.data_valid) begin
                    sr_q           <= {SYNC_WORD, count_q, snap};
                    count_q        <= count_q + 8'd1;
                    state_q        <= StSync;
                    bit_q          <= BitW'(7);
                    div_q          <= '0;
                    busy_q         <= 1'b1;
                    tx_frame_q     <= 1'b1;
                    tx_bit_start_q <= 1'b1;
                    tx_data_q      <= SYNC_WORD[7];
                end
            end else if (!div_end) begin
                div_q          <= div_q + DivW'(1);
                tx_bit_start_q <= 1'b0;
            end else begin
                // Default move at a bit boundary: shift out the next bit of the current field.
                div_q          <= '0;
                tx_bit_start_q <= 1'b1;
                sr_q           <= sr_q << 1;
                tx_data_q      <= next_bit;
                bit_q          <= bit_q - BitW'(1);
                unique case (state_q)
                    StSync: begin
                        if (last_bit) begin
                            state_q <= StCount;
                            bit_q   <= BitW'(7);
                        end
                    end
                    StCount: begin
                        if (last_bit) begin
                            state_q <= StData;
                            bit_q   <= BitW'(WORD_WIDTH - 1);
                            chan_q  <= '0;
`ifdef CIC_READOUT_PARITY_EN
                            par_q   <= next_bit;
`endif
                        end
                    end
`ifdef CIC_READOUT_PARITY_EN
                    StData: begin
                        if (!last_bit) begin
                            par_q <= par_q ^ next_bit;
                        end else begin
                            state_q   <= StParity;
                            tx_data_q <= par_q;
                            sr_q      <= sr_q;
                            bit_q     <= bit_q;
                        end
                    end
                    StParity: begin
                        if (last_chan) begin
                            state_q        <= StIdle;
                            busy_q         <= 1'b0;
                            tx_frame_q     <= 1'b0;
                            tx_data_q      <= 1'b0;
                            tx_bit_start_q <= 1'b0;
                        end else begin
                            state_q <= StData;
                            chan_q  <= chan_q + ChW'(1);
                            bit_q   <= BitW'(WORD_WIDTH - 1);
                            par_q   <= next_bit;
                        end
                    end
`else
                    StData: begin
                        if (last_bit && last_chan) begin
                            state_q        <= StIdle;
                            busy_q         <= 1'b0;
                            tx_frame_q     <= 1'b0;
                            tx_data_q      <= 1'b0;
                            tx_bit_start_q <= 1'b0;
                        end else if (last_bit) begin
                            chan_q <= chan_q + ChW'(1);
                            bit_q  <= BitW'(WORD_WIDTH - 1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_frame     = tx_frame_q;
    assign bus.tx_bit_start = tx_bit_start_q;
    assign bus.frame_count  = count_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_cic_row_readout.sv
// Bench for cic_row_readout: a default-size row plus a tiny row used for the frame_count wrap.
module tb_cic_row_readout;
    localparam int NA = 24, WA = 25, DA = 4;
    localparam int NB = 3, WB = 5, DB = 1;
`ifdef CIC_READOUT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FA = (16 + NA * (WA + PB)) * DA;
    localparam int FB = (16 + NB * (WB + PB)) * DB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] words [0:255];

    always #5 clk = ~clk;

    cic_row_readout_if #(.NUM_CHANNELS(NA), .WORD_WIDTH(WA)) bus_a ();
    cic_row_readout_if #(.NUM_CHANNELS(NB), .WORD_WIDTH(WB)) bus_b ();

    cic_row_readout #(.NUM_CHANNELS(NA), .WORD_WIDTH(WA), .CLK_DIV(DA), .SYNC_WORD(8'hA5))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    cic_row_readout #(.NUM_CHANNELS(NB), .WORD_WIDTH(WB), .CLK_DIV(DB), .SYNC_WORD(8'hA5))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    wire       s_busy    = sel ? bus_b.busy : bus_a.busy;
    wire       s_data    = sel ? bus_b.tx_data : bus_a.tx_data;
    wire       s_frame   = sel ? bus_b.tx_frame : bus_a.tx_frame;
    wire       s_bstart  = sel ? bus_b.tx_bit_start : bus_a.tx_bit_start;
    wire       s_overrun = sel ? bus_b.overrun : bus_a.overrun;
    wire [7:0] s_count   = sel ? bus_b.frame_count : bus_a.frame_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dv(input logic v);
        if (sel) bus_b.data_valid = v;
        else bus_a.data_valid = v;
    endtask

    task automatic set_clr(input logic v);
        if (sel) bus_b.overrun_clr = v;
        else bus_a.overrun_clr = v;
    endtask

    task automatic rand_words();
        for (int j = 0; j < 256; j++) words[j] = $urandom & 32'h01FF_FFFF;
    endtask

    task automatic scramble();
        for (int j = 0; j < NA; j++) bus_a.data_in[j*WA +: WA] = WA'($urandom);
        for (int j = 0; j < NB; j++) bus_b.data_in[j*WB +: WB] = WB'($urandom);
    endtask

    // Present the words, strobe once, then trash data_in so only the snapshot can be sent.
    task automatic start_frame();
        for (int j = 0; j < NA; j++) bus_a.data_in[j*WA +: WA] = words[j][WA-1:0];
        for (int j = 0; j < NB; j++) bus_b.data_in[j*WB +: WB] = words[j][WB-1:0];
        set_dv(1'b1);
        tick();
        set_dv(1'b0);
        scramble();
    endtask

    // Called one cycle after the accepting edge; walks the frame cycle by cycle.
    task automatic recv_frame(input int n, input int w, input int d, input logic [7:0] cnt,
                              input int strobe_at, input int clr_at, input int abort_at);
        logic [7:0] sw;
        logic [31:0] wd;
        bit eb[$];
        bit p;
        int bad_bits, bad_ctl, total;
        sw = 8'hA5;
        bad_bits = 0;
        bad_ctl = 0;
        for (int i = 7; i >= 0; i--) eb.push_back(sw[i]);
        for (int i = 7; i >= 0; i--) eb.push_back(cnt[i]);
        for (int c = 0; c < n; c++) begin
            wd = words[c];
            p = 1'b0;
            for (int i = w - 1; i >= 0; i--) begin
                eb.push_back(wd[i]);
                p = p ^ wd[i];
            end
            if (PB != 0) eb.push_back(p);
        end
        total = eb.size() * d;
        for (int k = 1; k <= total; k++) begin
            if (k == abort_at) break;
            if (s_data !== eb[(k-1)/d]) bad_bits++;
            if ({s_busy, s_frame, s_bstart} !== {2'b11, ((k - 1) % d) == 0}) bad_ctl++;
            if (k == strobe_at) set_dv(1'b1);
            if (k == clr_at) set_clr(1'b1);
            tick();
            set_dv(1'b0);
            set_clr(1'b0);
        end
        check("frame_bits", bad_bits, 0);
        check("frame_ctl", bad_ctl, 0);
        if (abort_at == 0) check("idle_after", {s_busy, s_frame, s_data, s_bstart}, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt;
        bit drop;
        bus_a.data_in = '0;
        bus_a.data_valid = 1'b0;
        bus_a.overrun_clr = 1'b0;
        bus_b.data_in = '0;
        bus_b.data_valid = 1'b0;
        bus_b.overrun_clr = 1'b0;
        repeat (3) tick();
        check("reset_a", {bus_a.busy, bus_a.tx_data, bus_a.tx_frame, bus_a.tx_bit_start,
                          bus_a.overrun, bus_a.frame_count}, 0);
        check("reset_b", {bus_b.busy, bus_b.tx_frame, bus_b.overrun, bus_b.frame_count}, 0);
        reset = 1'b0;
        tick();

        // Ramp pattern, then a back-to-back frame with a strobe on its final cycle.
        for (int j = 0; j < 256; j++) words[j] = j + 1;
        start_frame();
        recv_frame(NA, WA, DA, 8'h00, 0, 0, 0);
        check("count_after_1", s_count, 1);
        check("no_overrun", s_overrun, 0);
        rand_words();
        start_frame();
        recv_frame(NA, WA, DA, 8'h01, FA, 0, 0);
        check("drop_sets_overrun", s_overrun, 1);
        check("drop_keeps_count", s_count, 2);

        set_clr(1'b1);
        tick();
        set_clr(1'b0);
        check("clr_alone", s_overrun, 0);

        rand_words();
        start_frame();
        recv_frame(NA, WA, DA, 8'h02, 100, 100, 0);
        check("set_beats_clr", s_overrun, 1);
        check("count_after_3", s_count, 3);
        set_clr(1'b1);
        tick();
        set_clr(1'b0);

        // All-ones word and a two-ones word exercise both parity values.
        rand_words();
        words[0] = 32'h01FF_FFFF;
        words[1] = 32'h0000_0003;
        start_frame();
        recv_frame(NA, WA, DA, 8'h03, 0, 0, 0);
        check("count_after_4", s_count, 4);

        rand_words();
        start_frame();
        recv_frame(NA, WA, DA, 8'h04, 0, 0, 300 * DA + 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_outputs", {bus_a.busy, bus_a.tx_data, bus_a.tx_frame, bus_a.tx_bit_start,
                                bus_a.overrun, bus_a.frame_count}, 0);
        tick();
        check("abort_stays_idle", {s_busy, s_frame}, 0);
        rand_words();
        start_frame();
        recv_frame(NA, WA, DA, 8'h00, 0, 0, 0);
        check("count_after_clean", s_count, 1);

        // Small row: random words, gaps and drops across the frame_count wrap.
        sel = 1'b1;
        exp_cnt = 0;
        for (int f = 0; f < 258; f++) begin
            rand_words();
            repeat ($urandom_range(0, 2)) tick();
            drop = ($urandom_range(0, 7) == 0);
            start_frame();
            recv_frame(NB, WB, DB, 8'(exp_cnt), drop ? int'($urandom_range(1, FB)) : 0, 0, 0);
            exp_cnt = (exp_cnt + 1) % 256;
            check("wrap_count", s_count, exp_cnt);
            check("wrap_overrun", s_overrun, drop);
            set_clr(1'b1);
            tick();
            set_clr(1'b0);
        end
        check("wrap_final", s_count, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cic_row_readout.md
# cic_row_readout

Readout serializer for a row of CIC3 decimation filters: snapshots all filter output words on a sample strobe and ships them off the row as one framed, MSB-first serial stream. It is the consumer side of the filter row. It sits between the row's parallel output bus and the chip-level serial data pad/aggregator, and flags samples it had to drop because a frame was still in flight.

## Interface
- NUM_CHANNELS, 24, filters in the row (1..256)
- WORD_WIDTH, 25, bits per filter output word
- CLK_DIV, 4, clk cycles per serial bit (>=1)
- SYNC_WORD, 8'hA5, frame header byte
- clk  input  1  single system clock; all logic rising-edge
- reset  input  1  synchronous, active-high reset
- data_in  input  NUM_CHANNELS*WORD_WIDTH  filter outputs; channel j = data_in[j*WORD_WIDTH +: WORD_WIDTH]
- data_valid  input  1  one-cycle strobe: new decimated samples present on data_in
- overrun_clr  input  1  clears sticky overrun flag
- busy  output  1  frame in progress
- tx_data  output  1  serial data bit
- tx_frame  output  1  high for every bit of a frame
- tx_bit_start  output  1  high on the first clk cycle of each serial bit
- frame_count  output  8  count of accepted snapshots (mod 256)
- overrun  output  1  sticky: a data_valid was dropped

## Operation
- States: IDLE, SYNC, COUNT, DATA (plus PARITY when compiled in).
- IDLE: data_valid=1 -> latch whole data_in into shadow register, latch frame_count into header register, frame_count <= frame_count+1 (255 wraps to 0), go SYNC.
- SYNC: 8 bits of SYNC_WORD, MSB first -> COUNT.
- COUNT: 8 bits of latched count, MSB first (first frame after reset carries 0) -> DATA.
- DATA: channel 0 through NUM_CHANNELS-1, each WORD_WIDTH bits MSB first; after last bit of last channel -> IDLE.
- Frame length F = 16 + NUM_CHANNELS*WORD_WIDTH bits (616 at defaults).
- data_valid while busy=1: sample dropped, shadow register untouched, frame_count unchanged, overrun <= 1.
- overrun_clr=1 clears overrun; if drop and clear occur in the same cycle, set wins.
- data_in changes after capture have no effect on the frame in flight.
- Outputs when idle: tx_data=0, tx_frame=0, tx_bit_start=0.

## Timing
- Reset values: busy=0, tx_data=0, tx_frame=0, tx_bit_start=0, frame_count=0, overrun=0, state IDLE, all counters 0.
- Reset mid-frame: frame aborted; all outputs at reset values the following cycle; no partial-frame continuation.
- data_valid accepted in cycle t: busy, tx_frame high and tx_data = SYNC bit 7 from cycle t+1.
- Each bit held exactly CLK_DIV cycles; tx_bit_start high on cycle 1 of each bit only.
- Last bit occupies cycles up to t+F*CLK_DIV; at t+F*CLK_DIV+1 busy=0, tx_frame=0.
- data_valid at t+F*CLK_DIV is dropped (overrun). data_valid at t+F*CLK_DIV+1 is accepted, so the minimum inter-frame gap is 1 idle cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- CIC_READOUT_PARITY_EN defined: after each channel word, one even-parity bit is sent (word plus parity has an even count of ones). SYNC and COUNT fields carry no parity. F = 16 + NUM_CHANNELS*(WORD_WIDTH+1) (640 at defaults).
- Undefined: no parity bits, F as above; the PARITY state and its logic are absent.

## Test plan
- Reset, then data_valid with channel j = j+1 (defaults, no parity) -> stream A5, 00, then 25'd1..25'd24 MSB first. Busy for exactly 2464 cycles. frame_count=1.
- Back-to-back: second data_valid exactly at cycle t+2465 -> accepted, header count=01. A third strobe at t+2465+2464 -> dropped, overrun=1, frame_count stays 2.
- Overrun clear: drop sets overrun, then overrun_clr pulsed alone -> overrun=0. Overrun_clr in the same cycle as a new drop -> overrun=1.
- Reset asserted mid-DATA (bit 300) -> next cycle all outputs 0, frame_count=0. A subsequent data_valid starts a clean frame with count 00.
- frame_count wrap: 256 accepted frames -> frame 256 header byte FF, frame 257 header 00.
- With CIC_READOUT_PARITY_EN and channel 0=25'h1FFFFFF (25 ones) -> parity bit 1. Channel 1=25'h0000003 -> parity bit 0. Frame length 640 bits.
